// File: rtl/input_arbiter.sv
// input_arbiter: round-robin sharing of one CPU input port among N_REQ requesters,
// presenting each winner's word through a SETUP / STROBE / GAP handshake on ready_out.
module input_arbiter #(
  parameter int BUS_WIDTH    = 8,
  parameter int N_REQ        = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BUS_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           ack,
  output logic [BUS_WIDTH-1:0]       out_port,
  output logic                       ready_out,
  output logic                       busy
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;
  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IW-1:0]        ptr_q, ptr_d, win, idx;
  logic [N_REQ-1:0]     grant_q, grant_d, ack_q, ack_d;
  logic [BUS_WIDTH-1:0] data_q, data_d, sel;
  logic                 ready_q, ready_d;
  // Scan downward so the lowest offset from the pointer is the last assignment to win.
  always_comb begin
    win = '0;
    idx = '0;
    sel = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (req[idx]) win = idx;
    end
    for (int k = 0; k < N_REQ; k++)
      if (win == IW'(k)) sel = req_data[k*BUS_WIDTH +: BUS_WIDTH];
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    case (state_q)
      IDLE: if (|req) begin
        state_d = SETUP;
        cnt_d   = 4'(SETUP_CYCLES - 1);
        ptr_d   = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        grant_d = N_REQ'(1) << win;
        data_d  = sel;
      end
      SETUP: begin
        state_d = (cnt_q == 4'd0) ? STROBE : SETUP;
        cnt_d   = (cnt_q == 4'd0) ? 4'(HOLD_CYCLES - 1) : cnt_q - 4'd1;
      end
      STROBE: begin
        state_d = (cnt_q == 4'd0) ? GAP : STROBE;
        cnt_d   = (cnt_q == 4'd0) ? 4'(GAP_CYCLES - 1) : cnt_q - 4'd1;
        ack_d   = (cnt_q == 4'd0) ? grant_q : '0;
      end
      GAP: begin
        state_d = (cnt_q == 4'd0) ? IDLE : GAP;
        cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        grant_d = (cnt_q == 4'd0) ? '0 : grant_q;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == STROBE);
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end
  assign grant     = grant_q;
  assign ack       = ack_q;
  assign out_port  = data_q;
  assign ready_out = ready_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: doc/input_arbiter.md
INPUT_ARBITER -- requirements
Module: input_arbiter

Interface
REQ-001 Parameter BUS_WIDTH, default 8: width of each requester data word and of out_port.
REQ-002 Parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-003 Parameter SETUP_CYCLES, default 2: cycles data is stable before ready_out rises; legal range 1..15.
REQ-004 Parameter HOLD_CYCLES, default 4: cycles ready_out stays high; legal range 1..15.
REQ-005 Parameter GAP_CYCLES, default 2: cycles ready_out stays low after a strobe; legal range 1..15.
REQ-006 Ports, listed in this order:
- clk  input  1  sole clock; all state changes on its rising edge.
- n_reset  input  1  reset, asynchronous, active-low.
- req  input  N_REQ  per-requester request level.
- req_data  input  N_REQ*BUS_WIDTH  packed data; requester i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- grant  output  N_REQ  one-hot; the requester currently being served.
- ack  output  N_REQ  one-hot, one-cycle pulse; the served requester's transfer is complete.
- out_port  output  BUS_WIDTH  data driven to the CPU in_port.
- ready_out  output  1  strobe driven to the CPU ready_in.
- busy  output  1  high whenever the state is not IDLE.

Function
REQ-007 The block SHALL share the single CPU input port among N_REQ requesters, one transfer at a time.
REQ-008 The FSM SHALL have exactly four states, IDLE, SETUP, STROBE and GAP, with transitions IDLE->SETUP->STROBE->GAP->IDLE.
REQ-009 In IDLE, if any req bit is high at a rising edge, the block SHALL pick a winner by round-robin, latch that requester's req_data into out_port, set its grant bit and enter SETUP on that same edge.
REQ-010 Round-robin SHALL search upward from (last winner + 1) mod N_REQ and wrap around.
REQ-011 After reset, the search SHALL start at requester 0.
REQ-012 SETUP SHALL last SETUP_CYCLES cycles, STROBE HOLD_CYCLES cycles and GAP GAP_CYCLES cycles, each timed by one shared down-counter reloaded on every state entry.
REQ-013 ready_out SHALL be a registered output that is high exactly during the STROBE cycles and low in all other states.
REQ-014 out_port and grant SHALL hold constant from SETUP entry through the last GAP cycle, regardless of any change on req or req_data.
REQ-015 ack SHALL pulse high for the first GAP cycle only, on the served requester's bit only.
REQ-016 grant SHALL clear on entry to IDLE.
REQ-017 out_port SHALL keep the last transferred value while in IDLE.
REQ-018 After every transfer the block SHALL spend at least one cycle in IDLE before the next arbitration takes effect.
- Minimum transfer period: SETUP_CYCLES + HOLD_CYCLES + GAP_CYCLES + 1 cycles.
REQ-019 If a served requester drops req after grant, the transfer SHALL still complete and be acked.
REQ-020 A requester that still holds req after its ack SHALL be treated as a new request.
REQ-021 If several req bits rise in the same cycle, exactly one grant SHALL be issued, chosen per REQ-010.
REQ-022 If only one requester is active, it SHALL be served repeatedly with no starvation and no lockout.
REQ-023 busy SHALL be high in SETUP, STROBE and GAP, and low in IDLE.

Reset
REQ-024 Asserting n_reset low SHALL immediately force, without waiting for a clock edge:
- state = IDLE, counter = 0, round-robin pointer to requester 0;
- out_port = 0, ready_out = 0, grant = 0, ack = 0, busy = 0.
REQ-025 Reset asserted mid-transfer, including during STROBE, SHALL abort the transfer with no ack, and ready_out SHALL fall in the same cycle.
REQ-026 After n_reset deasserts, the first arbitration SHALL occur on the first rising edge at which req is non-zero.

Verification
REQ-027 The bench SHALL cover the following directed scenarios (defaults apply unless a scenario states otherwise):
- Single request: req=0001, data0=0xA5 at edge 0 -> grant=0001 and out_port=0xA5 from cycle 1; ready_out high cycles 3-6; ack=0001 in cycle 7; busy low from cycle 9.
- Simultaneous requests: req=1111, data i = 0x10+i, held -> out_port sequence 0x10, 0x11, 0x12, 0x13, 0x10; each transfer is 9 cycles, with 1 IDLE cycle between transfers.
- Withdrawn request: req1 drops one cycle after grant=0010 -> full strobe still occurs; ack=0010 is still issued.
- Data change during transfer: req_data altered during STROBE -> out_port unchanged until the next arbitration.
- Mid-strobe reset: n_reset low in the second STROBE cycle -> ready_out, grant and out_port all 0 immediately, no ack; after release, req=0100 is granted first.
- Parameter sweep: SETUP_CYCLES=1, HOLD_CYCLES=1, GAP_CYCLES=1 -> ready_out high for exactly 1 cycle; transfer period is 4 cycles.
